fpu_mul_arbiter: RTL and testbench

Sequencer and round-robin arbiter sharing one multi-cycle IEEE-754 single-precision multiplier among `NREQ` requesters. The multiplier has no done flag: it starts on a multi-cycle start pulse and produces its result a fixed number of cycles later. This block accepts one operand pair at a time and holds the operands stable for the whole operation. It times the start pulse and the latency window, captures the product, and returns it to the granted requester over a valid/ready handshake. It sits between the FPU issue logic and the `IEEE_multiplier` instance.

---
 rtl/fpu_mul_arbiter.sv | 130 +++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_arbiter.sv
// Round-robin sequencer that shares one fixed-latency IEEE-754 multiplier among
// NREQ requesters: it times the start pulse and latency window and returns the product.
module fpu_mul_arbiter #(
  parameter int NREQ         = 4,
  parameter int START_CYCLES = 5,
  parameter int MUL_LATENCY  = 30,
  localparam int GW          = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [31:0]        rsp_result,
  output logic [31:0]        mul_number1,
  output logic [31:0]        mul_number2,
  output logic               mul_start,
  input  logic [31:0]        mul_result,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  localparam int CMAX = (START_CYCLES > MUL_LATENCY) ? START_CYCLES : MUL_LATENCY;
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] sel;
  logic          sel_valid;
  logic          accept;
  logic          start_done;
  logic          wait_done;
  logic          resp_done;
  logic [31:0]   a_arr [NREQ];
  logic [31:0]   b_arr [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[32*i +: 32];
      b_arr[i] = req_b[32*i +: 32];
    end
  end

  // Round robin: first valid requester after the most recent grant wins.
  always_comb begin
    logic [GW-1:0] idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_valid = 1'b0;
    sel       = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NREQ);
      if (!sel_valid && req_valid[idx]) begin
        sel_valid = 1'b1;
        sel       = idx;
      end
    end
  end

  // Reset is folded in so no accept strobe is shown while reset is held.
  assign accept     = (state == IDLE) && sel_valid && !rstn;
  assign start_done = (state == START) && (cnt == CW'(START_CYCLES - 1));
  assign wait_done  = (state == WAIT)  && (cnt == CW'(MUL_LATENCY - 1));
  assign resp_done  = (state == RESP)  && rsp_ready[grant_id];

  always_ff @(posedge clk or posedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rstn) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    mul_start = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready[sel] = 1'b1;
          state_nx       = START;
        end
      end
      START: begin
        mul_start = 1'b1;
        if (start_done) state_nx = WAIT;
      end
      WAIT: begin
        if (wait_done) state_nx = RESP;
      end
      RESP: begin
        rsp_valid[grant_id] = 1'b1;
        if (resp_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      cnt         <= '0;
      last_grant  <= GW'(NREQ - 1);
      grant_id    <= '0;
      mul_number1 <= '0;
      mul_number2 <= '0;
      rsp_result  <= '0;
    end else begin
      if ((state == START && !start_done) || (state == WAIT && !wait_done))
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      // Operands are captured once and held until the next accept.
      if (accept) begin
        mul_number1 <= a_arr[sel];
        mul_number2 <= b_arr[sel];
        grant_id    <= sel;
      end
      if (wait_done) rsp_result <= mul_result;
      if (resp_done) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Scoreboard bench for fpu_mul_arbiter with a fixed-latency multiplier model that
// only presents the product in the one cycle the arbiter is supposed to sample it.
module tb_fpu_mul_arbiter;

  localparam int NREQ = 4;
  localparam int S    = 5;
  localparam int L    = 30;

  logic               clk;
  logic               rstn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_result;
  logic [31:0]        mul_number1;
  logic [31:0]        mul_number2;
  logic               mul_start;
  logic [31:0]        mul_result;
  logic               busy;
  logic [1:0]         grant_id;

  fpu_mul_arbiter #(.NREQ(NREQ), .START_CYCLES(S), .MUL_LATENCY(L)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .mul_number1(mul_number1), .mul_number2(mul_number2),
    .mul_start(mul_start), .mul_result(mul_result), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40ADD2F2_4016147B: return 32'h414BCF04;
      64'h4133AE14_4143AE14: return 32'h430957C8;
      64'h3FC58106_3FB74BC7: return 32'h400D69B2;
      default:               return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0001;
    endcase
  endfunction

  function automatic int first_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int lg);
    for (int k = 1; k <= NREQ; k++) if (v[(lg + k) % NREQ]) return (lg + k) % NREQ;
    return -1;
  endfunction

  // Multiplier model: result is only meaningful L cycles after start falls.
  int cyc  = 0;
  int wcnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (mul_start) wcnt <= 1;
    else if (wcnt != 0 && wcnt < 1000) wcnt <= wcnt + 1;
  end
  assign mul_result = (wcnt == L) ? mul_model(mul_number1, mul_number2) : 32'hDEADBEEF;

  typedef struct { int id; logic [31:0] res; } sb_t;
  sb_t sb_q[$];
  int  glog[$];

  int          last_g = NREQ - 1;
  logic [31:0] acc_a = '0, acc_b = '0;
  int          acc_cyc = 0, start_run = 0, resp_len = 0, last_resp_len = 0;
  int          n_acc = 0, n_hs = 0;
  bit          prev_rv = 0, b2b = 0;
  logic [NREQ-1:0] rv_hold, acc_mask = '0;
  logic [31:0]     res_hold;

  always @(negedge clk) begin
    logic [NREQ-1:0] acc;
    int gid;
    logic [31:0] a, b;
    sb_t e;
    if (rstn) begin
      sb_q.delete();
      last_g = NREQ - 1; acc_a = '0; acc_b = '0;
      start_run = 0; prev_rv = 0; b2b = 0; acc_mask = '0;
    end else begin
      check("num1_hold", mul_number1, acc_a);
      check("num2_hold", mul_number2, acc_b);
      if (busy) check("ready_only_idle", 32'(req_ready), 0);
      if (b2b) begin
        if (req_valid != 0) check("b2b_accept", 32'(|(req_valid & req_ready)), 1);
        b2b = 0;
      end
      if (mul_start) start_run++;
      else if (start_run != 0) begin
        check("start_len", start_run, S);
        start_run = 0;
      end
      acc = req_valid & req_ready;
      if (acc != 0) begin
        check("ready_onehot", 32'($onehot(req_ready)), 1);
        gid = first_idx(acc);
        check("grant_rr", gid, rr_pick(req_valid, last_g));
        a = req_a[gid*32 +: 32];
        b = req_b[gid*32 +: 32];
        sb_q.push_back('{gid, mul_model(a, b)});
        glog.push_back(gid);
        acc_a = a; acc_b = b; acc_cyc = cyc;
        acc_mask |= acc;
        n_acc++;
      end
      if (rsp_valid != 0) begin
        if (!prev_rv) begin
          check("rsp_latency", cyc - acc_cyc, S + L + 1);
          check("rsp_onehot", 32'($onehot(rsp_valid)), 1);
          if (sb_q.size() != 0) check("grant_id_out", 32'(grant_id), sb_q[0].id);
          rv_hold = rsp_valid; res_hold = rsp_result; resp_len = 0;
        end else begin
          check("rsp_valid_stable", 32'(rsp_valid), 32'(rv_hold));
          check("rsp_result_stable", rsp_result, res_hold);
        end
        resp_len++;
        prev_rv = 1;
        if ((rsp_valid & rsp_ready) != 0) begin
          gid = first_idx(rsp_valid);
          if (sb_q.size() == 0) check("sb_underflow", 1, 0);
          else begin
            e = sb_q.pop_front();
            check("rsp_id", gid, e.id);
            check("rsp_result", rsp_result, e.res);
          end
          last_g = gid; last_resp_len = resp_len;
          b2b = 1; prev_rv = 0;
          n_hs++;
        end
      end else prev_rv = 0;
    end
  end

  bit auto_drop = 1, scramble = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc_mask;
    acc_mask = '0;
    if (scramble)
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*32 +: 32] = $urandom;
        req_b[i*32 +: 32] = $urandom;
      end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic do_reset(input logic [NREQ-1:0] v);
    rstn = 1'b1;
    step(); step();
    req_valid = v;
    glog.delete();
    rstn = 1'b0;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int tgt = n_acc + n;
    for (int k = 0; k < budget && n_acc < tgt; k++) step();
    if (n_acc < tgt) check("timeout_accept", 0, 1);
  endtask

  task automatic wait_hs(input int n, input int budget);
    int tgt = n_hs + n;
    for (int k = 0; k < budget && n_hs < tgt; k++) step();
    if (n_hs < tgt) check("timeout_handshake", 0, 1);
  endtask

  initial begin
    logic [31:0] r_hold, n1_hold, n2_hold;
    int k;
    rstn = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    step(); step();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_num1", mul_number1, 0);
    check("rst_num2", mul_number2, 0);
    check("rst_grant_id", 32'(grant_id), 0);

    // Single request, response ready raised well before the product arrives.
    set_ops(0, 32'h40ADD2F2, 32'h4016147B);
    do_reset(4'b0001);
    wait_acc(1, 20);
    repeat (20) step();
    rsp_ready[0] = 1'b1;
    wait_hs(1, 60);
    check("resp_len_one", last_resp_len, 1);

    // Simultaneous requests from reset.
    set_ops(1, 32'h4133AE14, 32'h4143AE14);
    set_ops(2, 32'h3FC58106, 32'h3FB74BC7);
    rsp_ready = '1;
    do_reset(4'b0111);
    wait_hs(3, 150);
    check("simul_count", glog.size(), 3);
    for (int i = 0; i < 3 && i < glog.size(); i++) check("simul_order", glog[i], i);

    // Round-robin fairness with all requesters held valid.
    auto_drop = 0;
    for (int i = 0; i < NREQ; i++) set_ops(i, $urandom, $urandom);
    do_reset(4'b1111);
    wait_hs(8, 8 * 45);
    for (int i = 0; i < 8 && i < glog.size(); i++) check("rr_seq", glog[i], i % NREQ);
    auto_drop = 1;

    // Response backpressure; other requesters' ready bits must be ignored.
    rsp_ready = '0;
    do_reset(4'b0010);
    k = 0;
    while (rsp_valid == 0 && k < 100) begin step(); k++; end
    if (rsp_valid == 0) check("timeout_bp_rsp", 0, 1);
    req_valid = 4'b1111; rsp_ready = 4'b1101;
    r_hold = rsp_result; n1_hold = mul_number1; n2_hold = mul_number2;
    repeat (10) step();
    check("bp_rsp_valid", 32'(rsp_valid), 32'(4'b0010));
    check("bp_rsp_result", rsp_result, r_hold);
    check("bp_req_ready", 32'(req_ready), 0);
    check("bp_num1", mul_number1, n1_hold);
    check("bp_num2", mul_number2, n2_hold);
    glog.delete();
    rsp_ready = '1;
    wait_hs(1, 5);
    wait_acc(1, 5);
    if (glog.size() != 0) check("bp_next_grant", glog[0], 2);

    // Reset during WAIT, between clock edges.
    do_reset(4'b0100);
    wait_acc(1, 20);
    repeat (S + 3) step();
    #2;
    rstn = 1'b1;
    #1;
    check("mid_rst_mul_start", 32'(mul_start), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_grant_id", 32'(grant_id), 0);
    step(); step();
    glog.delete();
    req_valid = 4'b0101;
    rstn = 1'b0;
    wait_acc(1, 10);
    if (glog.size() != 0) check("post_rst_first_grant", glog[0], 0);
    wait_hs(2, 120);

    // Operand stability while the request bus changes every cycle.
    set_ops(0, 32'h40ADD2F2, 32'h4016147B);
    do_reset(4'b0001);
    wait_acc(1, 20);
    scramble = 1;
    wait_hs(1, 60);
    repeat (3) step();
    scramble = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
